// File: rtl/la_gpio_pkg.sv
// Shared definitions for the UMI GPIO host: UMI opcodes, remote register
// offsets, FSM/transaction typedefs and the response-timeout width.
package la_gpio_pkg;

    localparam logic [4:0] UMI_REQ_RD  = 5'h01;
    localparam logic [4:0] UMI_REQ_WR  = 5'h03;
    localparam logic [4:0] UMI_RESP_RD = 5'h02;
    localparam logic [4:0] UMI_RESP_WR = 5'h04;

    localparam logic [7:0] REG_IN  = 8'h00;
    localparam logic [7:0] REG_OUT = 8'h08;
    localparam logic [7:0] REG_OE  = 8'h10;

    localparam int TO_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        TXN_OUT,
        TXN_OE,
        TXN_RD
    } txn_t;

    // UMI size field encodes log2 of the bytes moved per beat
    function automatic logic [2:0] umi_size(input int rw);
        return 3'($clog2(rw / 8));
    endfunction

endpackage

// File: rtl/la_gpio_host_req.sv
// Request register slice: captures a request on load and holds valid plus
// all fields stable until the fabric accepts it with ready.
module la_gpio_host_req
    import la_gpio_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 128,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load,
    input  logic [CW-1:0] load_cmd,
    input  logic [AW-1:0] load_dstaddr,
    input  logic [AW-1:0] load_srcaddr,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [CW-1:0] cmd,
    output logic [AW-1:0] dstaddr,
    output logic [AW-1:0] srcaddr,
    output logic [DW-1:0] data
);

    logic          valid_reg;
    logic [CW-1:0] cmd_reg;
    logic [AW-1:0] dstaddr_reg;
    logic [AW-1:0] srcaddr_reg;
    logic [DW-1:0] data_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_reg   <= 1'b0;
            cmd_reg     <= '0;
            dstaddr_reg <= '0;
            srcaddr_reg <= '0;
            data_reg    <= '0;
        end else if (load) begin
            valid_reg   <= 1'b1;
            cmd_reg     <= load_cmd;
            dstaddr_reg <= load_dstaddr;
            srcaddr_reg <= load_srcaddr;
            data_reg    <= load_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid   = valid_reg;
    assign cmd     = cmd_reg;
    assign dstaddr = dstaddr_reg;
    assign srcaddr = srcaddr_reg;
    assign data    = data_reg;

endmodule

// File: rtl/la_gpio_host.sv
// UMI initiator mirroring a remote la_gpio block: pushes OUT/OE writes and
// polls IN. Optional response timeout: define LA_GPIO_HOST_TIMEOUT_EN.
module la_gpio_host
    import la_gpio_pkg::*;
#(
    parameter      TARGET = "DEFAULT",
    parameter int  RW     = 32,
    parameter int  DW     = 128,
    parameter int  AW     = 64,
    parameter int  CW     = 32,
    parameter int  N      = 8,
    parameter int  POLL   = 256
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          enable,
    input  logic [AW-1:0] devaddr,
    input  logic [AW-1:0] hostaddr,
    input  logic [N-1:0]  gpio_out,
    input  logic [N-1:0]  gpio_oe,
    output logic [N-1:0]  gpio_in,
    output logic          gpio_irq,
    output logic          err,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam int            PW          = (POLL > 1) ? $clog2(POLL) : 1;
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL - 1);
    localparam logic [2:0]    SIZE        = umi_size(RW);

    state_t        state_reg, state_next;
    txn_t          txn_reg;
    logic [N-1:0]  sent_reg;
    logic [N-1:0]  sh_out_reg, sh_oe_reg;
    logic [N-1:0]  gpio_in_reg;
    logic          irq_reg;
    logic          err_reg;
    logic [PW-1:0] poll_cnt_reg;

    logic          sel_load;
    txn_t          sel_txn;
    logic [N-1:0]  sel_val;
    logic [4:0]    sel_op;
    logic [7:0]    sel_off;
    logic [CW-1:0] sel_cmd;
    logic [DW-1:0] sel_data;
    logic          resp_ready;
    logic          resp_fire;
    logic          resp_match;
    logic          timeout_hit;
    logic          timeout_fire;
    logic          stale_pending;
    logic          stale_fire;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_load     = 1'b0;
        sel_txn      = TXN_RD;
        sel_val      = '0;
        resp_ready   = 1'b0;
        resp_fire    = 1'b0;
        timeout_fire = 1'b0;
        stale_fire   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    if (gpio_out != sh_out_reg) begin
                        sel_load = 1'b1;
                        sel_txn  = TXN_OUT;
                        sel_val  = gpio_out;
                    end else if (gpio_oe != sh_oe_reg) begin
                        sel_load = 1'b1;
                        sel_txn  = TXN_OE;
                        sel_val  = gpio_oe;
                    end else if (poll_cnt_reg == '0) begin
                        sel_load = 1'b1;
                        sel_txn  = TXN_RD;
                    end
                end
                if (sel_load) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (uhost_req_valid && uhost_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                resp_ready = 1'b1;
                // A response left over from a timed-out request is swallowed
                if (uhost_resp_valid && stale_pending) begin
                    stale_fire = 1'b1;
                end else if (uhost_resp_valid) begin
                    resp_fire  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_op  = UMI_REQ_RD;
        sel_off = REG_IN;
        case (sel_txn)
            TXN_OUT: begin
                sel_op  = UMI_REQ_WR;
                sel_off = REG_OUT;
            end
            TXN_OE: begin
                sel_op  = UMI_REQ_WR;
                sel_off = REG_OE;
            end
            default: begin
                sel_op  = UMI_REQ_RD;
                sel_off = REG_IN;
            end
        endcase
        sel_cmd      = '0;
        sel_cmd[4:0] = sel_op;
        sel_cmd[7:5] = SIZE;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_data
            if (gi < N) begin : g_val
                assign sel_data[gi] = sel_val[gi];
            end else begin : g_zero
                assign sel_data[gi] = 1'b0;
            end
        end
    endgenerate

    assign resp_match = (uhost_resp_cmd[4:0] ==
                         ((txn_reg == TXN_RD) ? UMI_RESP_RD : UMI_RESP_WR));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            txn_reg      <= TXN_RD;
            sent_reg     <= '0;
            sh_out_reg   <= '0;
            sh_oe_reg    <= '0;
            gpio_in_reg  <= '0;
            irq_reg      <= 1'b0;
            err_reg      <= 1'b0;
            poll_cnt_reg <= POLL_RELOAD;
        end else begin
            irq_reg <= 1'b0;
            if (sel_load) begin
                txn_reg  <= sel_txn;
                sent_reg <= sel_val;
            end
            if (sel_load && (sel_txn == TXN_RD)) begin
                poll_cnt_reg <= POLL_RELOAD;
            end else if (enable && (poll_cnt_reg != '0)) begin
                poll_cnt_reg <= poll_cnt_reg - 1'b1;
            end
            if (resp_fire) begin
                if (resp_match) begin
                    case (txn_reg)
                        TXN_OUT: sh_out_reg <= sent_reg;
                        TXN_OE:  sh_oe_reg  <= sent_reg;
                        default: begin
                            gpio_in_reg <= uhost_resp_data[N-1:0];
                            irq_reg     <= (uhost_resp_data[N-1:0] != gpio_in_reg);
                        end
                    endcase
                end else begin
                    err_reg <= 1'b1;
                end
            end
            if (timeout_fire || stale_fire) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef LA_GPIO_HOST_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_reg;
    logic            stale_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            to_cnt_reg <= '0;
            stale_reg  <= 1'b0;
        end else begin
            to_cnt_reg <= (state_reg == ST_WAIT) ? to_cnt_reg + 1'b1 : '0;
            if (timeout_fire) begin
                stale_reg <= 1'b1;
            end else if (stale_fire) begin
                stale_reg <= 1'b0;
            end
        end
    end

    // Fires on the 65535th consecutive cycle spent waiting
    assign timeout_hit   = (to_cnt_reg == {{(TO_W-1){1'b1}}, 1'b0});
    assign stale_pending = stale_reg;
`else
    assign timeout_hit   = 1'b0;
    assign stale_pending = 1'b0;
`endif

    la_gpio_host_req #(
        .AW (AW),
        .DW (DW),
        .CW (CW)
    ) u_req (
        .clk          (clk),
        .nreset       (nreset),
        .load         (sel_load),
        .load_cmd     (sel_cmd),
        .load_dstaddr (devaddr + AW'(sel_off)),
        .load_srcaddr (hostaddr),
        .load_data    (sel_data),
        .ready        (uhost_req_ready),
        .valid        (uhost_req_valid),
        .cmd          (uhost_req_cmd),
        .dstaddr      (uhost_req_dstaddr),
        .srcaddr      (uhost_req_srcaddr),
        .data         (uhost_req_data)
    );

    logic unused_ok;
    assign unused_ok = ^{(TARGET == "DEFAULT"), uhost_resp_dstaddr, uhost_resp_srcaddr,
                         uhost_resp_data, uhost_resp_cmd};

    assign gpio_in          = gpio_in_reg;
    assign gpio_irq         = irq_reg;
    assign err              = err_reg;
    assign uhost_resp_ready = resp_ready;

endmodule

// File: tb/tb_la_gpio_host.sv
// Directed self-checking bench for la_gpio_host (POLL = 16); the timeout case
// runs only when LA_GPIO_HOST_TIMEOUT_EN is defined.
module tb_la_gpio_host;

    localparam int N = 8, AW = 64, DW = 128, CW = 32, RW = 32, POLL = 16;
    localparam logic [AW-1:0] DEV  = 64'h0000_0000_4000_0000;
    localparam logic [AW-1:0] HOST = 64'h0000_0000_0000_0100;

    logic          clk = 1'b0;
    logic          nreset, enable;
    logic [AW-1:0] devaddr, hostaddr;
    logic [N-1:0]  gpio_out, gpio_oe;
    logic [N-1:0]  gpio_in;
    logic          gpio_irq, err;
    logic          uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    la_gpio_host #(
        .TARGET ("DEFAULT"), .RW (RW), .DW (DW), .AW (AW), .CW (CW), .N (N), .POLL (POLL)
    ) dut (
        .clk                (clk),
        .nreset             (nreset),
        .enable             (enable),
        .devaddr            (devaddr),
        .hostaddr           (hostaddr),
        .gpio_out           (gpio_out),
        .gpio_oe            (gpio_oe),
        .gpio_in            (gpio_in),
        .gpio_irq           (gpio_irq),
        .err                (err),
        .uhost_req_valid    (uhost_req_valid),
        .uhost_req_cmd      (uhost_req_cmd),
        .uhost_req_dstaddr  (uhost_req_dstaddr),
        .uhost_req_srcaddr  (uhost_req_srcaddr),
        .uhost_req_data     (uhost_req_data),
        .uhost_req_ready    (uhost_req_ready),
        .uhost_resp_valid   (uhost_resp_valid),
        .uhost_resp_cmd     (uhost_resp_cmd),
        .uhost_resp_dstaddr (uhost_resp_dstaddr),
        .uhost_resp_srcaddr (uhost_resp_srcaddr),
        .uhost_resp_data    (uhost_resp_data),
        .uhost_resp_ready   (uhost_resp_ready)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, accept it in one cycle; returns on the
    // negedge following the handshake.
    task automatic accept_req(output logic [CW-1:0] c, output logic [AW-1:0] d,
                              output logic [DW-1:0] dat, output int t, output bit ok);
        ok = 1'b0; c = '0; d = '0; dat = '0; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uhost_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_eq("req_wait_timeout", 0, 1);
            return;
        end
        c = uhost_req_cmd; d = uhost_req_dstaddr; dat = uhost_req_data; t = cyc;
        check_eq("req_srcaddr", uhost_req_srcaddr, HOST);
        uhost_req_ready = 1'b1;
        @(negedge clk);
        uhost_req_ready = 1'b0;
        $display("t=%0d req cmd=0x%0h dst=0x%0h data=0x%0h", t, c, d, dat);
    endtask

    task automatic give_resp(input logic [CW-1:0] c, input logic [DW-1:0] dat);
        check_eq("resp_ready_in_wait", uhost_resp_ready, 1'b1);
        uhost_resp_valid = 1'b1;
        uhost_resp_cmd   = c;
        uhost_resp_data  = dat;
        @(negedge clk);
        uhost_resp_valid = 1'b0;
        uhost_resp_cmd   = '0;
        uhost_resp_data  = '0;
    endtask

    // Accept requests until one of the wanted kind arrives; others get a
    // well-formed response (remote IN reads as 0x81).
    task automatic get_req(input bit want_read, output logic [CW-1:0] c,
                           output logic [AW-1:0] d, output logic [DW-1:0] dat, output bit ok);
        int t;
        bit is_rd;
        ok = 1'b0; c = '0; d = '0; dat = '0;
        for (int k = 0; k < 8; k++) begin
            accept_req(c, d, dat, t, ok);
            if (!ok) return;
            is_rd = (c[4:0] == 5'h01);
            if (is_rd == want_read) return;
            give_resp(is_rd ? 32'h02 : 32'h04, is_rd ? 128'h81 : 128'h0);
        end
        ok = 1'b0;
        check_eq("get_req_kind", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] c;
        logic [AW-1:0] d;
        logic [DW-1:0] dat;
        logic [255:0]  snap;
        int            t1, t2, seen;
        bit            ok;

        nreset = 1'b0; enable = 1'b1; devaddr = DEV; hostaddr = HOST;
        gpio_out = 8'h5A; gpio_oe = 8'hFF;
        uhost_req_ready = 1'b0; uhost_resp_valid = 1'b0; uhost_resp_cmd = '0;
        uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_valid", uhost_req_valid, 1'b0);
        check_eq("rst_resp_ready", uhost_resp_ready, 1'b0);
        check_eq("rst_gpio_in", gpio_in, 8'h00);
        check_eq("rst_irq", gpio_irq, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_req_cmd", uhost_req_cmd, 32'h0);
        check_eq("rst_req_dst", uhost_req_dstaddr, 64'h0);
        nreset = 1'b1;

        // OUT write after reset, held 10 cycles with ready low
        @(negedge clk);
        check_eq("out_latency_valid", uhost_req_valid, 1'b1);
        check_eq("out_cmd", uhost_req_cmd, 32'h43);
        check_eq("out_dst", uhost_req_dstaddr, DEV + 64'h08);
        check_eq("out_data", uhost_req_data, 128'h5A);
        snap = {uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data[76:0]};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_stable", {uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr,
                                     uhost_req_srcaddr, uhost_req_data[76:0]}, snap);
        end
        uhost_req_ready = 1'b1;
        @(negedge clk);
        uhost_req_ready = 1'b0;
        $display("t=%0d req cmd=0x43 dst=0x%0h data=0x5A (held)", cyc, DEV + 64'h08);
        check_eq("one_accept_valid_low", uhost_req_valid, 1'b0);
        give_resp(32'h04, 128'h0);

        // OE write follows
        get_req(1'b0, c, d, dat, ok);
        check_eq("oe_cmd", c, 32'h43);
        check_eq("oe_dst", d, DEV + 64'h10);
        check_eq("oe_data", dat, 128'hFF);
        give_resp(32'h04, 128'h0);
        check_eq("oe_gpio_in_untouched", gpio_in, 8'h00);

        // Polling: first read returns 0x81 -> irq; second equal -> no irq
        accept_req(c, d, dat, t1, ok);
        check_eq("rd_cmd", c, 32'h41);
        check_eq("rd_dst", d, DEV);
        give_resp(32'h02, 128'h81);
        check_eq("rd1_gpio_in", gpio_in, 8'h81);
        check_eq("rd1_irq", gpio_irq, 1'b1);
        @(negedge clk);
        check_eq("rd1_irq_pulse", gpio_irq, 1'b0);
        accept_req(c, d, dat, t2, ok);
        check_eq("poll_interval", t2 - t1, 16);
        check_eq("rd2_cmd", c, 32'h41);
        give_resp(32'h02, 128'h81);
        check_eq("rd2_gpio_in", gpio_in, 8'h81);
        check_eq("rd2_no_irq", gpio_irq, 1'b0);

        // Input change while a write is in flight -> second write
        gpio_out = 8'h00;
        get_req(1'b0, c, d, dat, ok);
        check_eq("w0_data", dat, 128'h00);
        give_resp(32'h04, 128'h0);
        gpio_out = 8'h5A;
        get_req(1'b0, c, d, dat, ok);
        check_eq("w1_data", dat, 128'h5A);
        gpio_out = 8'h3C;
        give_resp(32'h04, 128'h0);
        get_req(1'b0, c, d, dat, ok);
        check_eq("w2_dst", d, DEV + 64'h08);
        check_eq("w2_data", dat, 128'h3C);
        give_resp(32'h04, 128'h0);

        // Wrong opcode on a read -> err, gpio_in kept
        get_req(1'b1, c, d, dat, ok);
        give_resp(32'h04, 128'h55);
        check_eq("bad_op_err", err, 1'b1);
        check_eq("bad_op_gpio_in", gpio_in, 8'h81);
        check_eq("bad_op_irq", gpio_irq, 1'b0);
        get_req(1'b1, c, d, dat, ok);
        give_resp(32'h02, 128'h81);
        check_eq("err_sticky", err, 1'b1);

        // Disabled: no traffic at all
        enable = 1'b0;
        gpio_oe = 8'h0F;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uhost_req_valid) seen++;
        end
        check_eq("disabled_no_req", seen, 0);

        // Reset in the middle of a request aborts it
        enable = 1'b1;
        for (int i = 0; i < 20 && !uhost_req_valid; i++) @(negedge clk);
        check_eq("pre_abort_valid", uhost_req_valid, 1'b1);
        nreset = 1'b0;
        #1;
        check_eq("abort_valid", uhost_req_valid, 1'b0);
        check_eq("abort_err", err, 1'b0);
        check_eq("abort_gpio_in", gpio_in, 8'h00);
        @(negedge clk);
        nreset = 1'b1;

`ifdef LA_GPIO_HOST_TIMEOUT_EN
        gpio_out = 8'h77;
        get_req(1'b0, c, d, dat, ok);
        check_eq("to_data", dat, 128'h77);
        seen = 0;
        for (int i = 0; i < 70000; i++) begin
            if (!uhost_resp_ready) break;
            @(negedge clk);
            seen++;
        end
        check_eq("to_cycles", seen, 65535);
        check_eq("to_err", err, 1'b1);
        check_eq("to_idle", uhost_resp_ready, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
